// File: rtl/clock_pkg.sv
// clock_pkg - definitions shared by the digital clock blocks.
//
// Contents:
//   - field widths of the packed time and date buses
//   - bit positions of each field inside those buses
//   - ASCII constants used by the serial time reporter
//   - the state encoding of the report sequencer
//   - small helpers that turn a binary field into printable digits
//
// Bus layout:
//   time bus {hour[4:0], min[5:0], sec[5:0]}
//   date bus {day[4:0], month[3:0], year[11:0]}
package clock_pkg;

  localparam int HOUR_W  = 5;
  localparam int MIN_W   = 6;
  localparam int SEC_W   = 6;
  localparam int DAY_W   = 5;
  localparam int MONTH_W = 4;
  localparam int YEAR_W  = 12;

  localparam int TIME_W = HOUR_W + MIN_W + SEC_W;
  localparam int DATE_W = DAY_W + MONTH_W + YEAR_W;

  localparam int SEC_LSB  = 0;
  localparam int MIN_LSB  = SEC_W;
  localparam int HOUR_LSB = SEC_W + MIN_W;

  localparam int YEAR_LSB  = 0;
  localparam int MONTH_LSB = YEAR_W;
  localparam int DAY_LSB   = YEAR_W + MONTH_W;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_DOT   = 8'h2E;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND
  } report_state_e;

  // Two decimal digits of a 6-bit field, packed {tens, ones}. Every input
  // is below 64, so the tens digit never exceeds 6 and fits its nibble.
  function automatic logic [7:0] bcd2(input logic [5:0] v);
    return (8'(v / 6'd10) << 4) | 8'(v % 6'd10);
  endfunction

  function automatic logic [7:0] ascii_digit(input logic [3:0] d);
    return ASCII_0 | {4'd0, d};
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte - 8N1 transmitter for a single byte.
//
// Parameters:
//   DIV   clock cycles per bit; must be at least 2
// Ports:
//   clk    system clock, rising edge
//   rst    asynchronous reset, active low
//   start  accepted while idle; data is captured in the same cycle
//   data   byte to send, LSB first
//   tx     serial line, idles high
//   done   one-cycle pulse in the last cycle of the stop bit
//
// The start bit appears on tx in the cycle after start. The frame is held
// in a shift register whose bit 0 drives tx directly, so tx comes straight
// from a flop, and the all-ones reset value puts the line high immediately.
module uart_tx_byte #(
  parameter int DIV = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam int CNT_W = $clog2(DIV);

  logic             active_q, active_d;
  logic [9:0]       shift_q, shift_d;
  logic [3:0]       bit_q, bit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bit_end;

  assign bit_end = (cnt_q == CNT_W'(DIV - 1));
  assign done    = active_q && bit_end && (bit_q == 4'd9);
  assign tx      = shift_q[0];

  // Shifting in ones leaves the register all ones after the stop bit, so
  // the line stays high between frames without a separate idle mux.
  always_comb begin
    active_d = active_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    cnt_d    = cnt_q;
    if (!active_q) begin
      if (start) begin
        active_d = 1'b1;
        shift_d  = {1'b1, data, 1'b0};
        bit_d    = 4'd0;
        cnt_d    = '0;
      end
    end else if (bit_end) begin
      cnt_d   = '0;
      shift_d = {1'b1, shift_q[9:1]};
      if (bit_q == 4'd9) begin
        active_d = 1'b0;
      end else begin
        bit_d = bit_q + 4'd1;
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_q <= 1'b0;
      shift_q  <= '1;
      bit_q    <= 4'd0;
      cnt_q    <= '0;
    end else begin
      active_q <= active_d;
      shift_q  <= shift_d;
      bit_q    <= bit_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/time_report_tx.sv
// time_report_tx - sends the current time as an ASCII line over a UART.
//
// Parameters:
//   CLK_FREQ  system clock in Hz
//   BAUD      serial bit rate; CLK_FREQ/BAUD must be at least 2
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous reset, active low
//   time_in  {hour, min, sec}, binary
//   date_in  {day, month, year}, binary; used only with DATE_REPORT_EN
//   report   one-cycle request for a single report line
//   auto_en  report automatically whenever the seconds field changes
//   tx       UART line, idles high
//   busy     high from the LOAD cycle until the last stop bit has ended
//
// Line sent: "HH:MM:SS" CR LF. When the macro DATE_REPORT_EN is defined,
// the line is prefixed with "DD.MM.YYYY ".
//
// A trigger that arrives while a line is in progress is remembered once
// and served directly after the current line; further ones are dropped.
module time_report_tx
  import clock_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TIME_W-1:0] time_in,
  input  logic [DATE_W-1:0] date_in,
  input  logic              report,
  input  logic              auto_en,
  output logic              tx,
  output logic              busy
);

  localparam int DIV = CLK_FREQ / BAUD;
`ifdef DATE_REPORT_EN
  localparam int PREFIX_LEN = 11;
`else
  localparam int PREFIX_LEN = 0;
`endif
  localparam int         N_BYTES  = PREFIX_LEN + 10;
  localparam logic [4:0] LAST_IDX = 5'(N_BYTES - 1);

  report_state_e     state_q, state_d;
  logic [4:0]        idx_q, idx_d;
  logic              pending_q, pending_d;
  logic              launch_q, launch_d;
  logic [SEC_W-1:0]  sec_prev_q, sec_prev_d;
  logic [TIME_W-1:0] time_q, time_d;
  logic [TIME_W-1:0] time_src;
  logic              trigger;
  logic              start;
  logic              done;
  logic [7:0]        byte_data;
  logic [4:0]        time_idx;
  logic [7:0]        hour_bcd, min_bcd, sec_bcd;

  assign busy       = (state_q != ST_IDLE);
  assign sec_prev_d = time_in[SEC_LSB +: SEC_W];
  assign trigger    = report || (auto_en && (time_in[SEC_LSB +: SEC_W] != sec_prev_q));

  // Byte 0 is handed to the transmitter during LOAD itself, before the
  // snapshot register has been written, so in that cycle the digits come
  // straight from the inputs being captured.
  assign time_d   = (state_q == ST_LOAD) ? time_in : time_q;
  assign time_src = time_d;

  assign hour_bcd = bcd2(6'(time_src[HOUR_LSB +: HOUR_W]));
  assign min_bcd  = bcd2(time_src[MIN_LSB +: MIN_W]);
  assign sec_bcd  = bcd2(time_src[SEC_LSB +: SEC_W]);

`ifdef DATE_REPORT_EN
  logic [DATE_W-1:0] date_q, date_d;
  logic [YEAR_W-1:0] year_v;
  logic [7:0]        day_bcd, month_bcd;
  logic [3:0]        year_th, year_hu, year_te, year_on;

  assign date_d    = (state_q == ST_LOAD) ? date_in : date_q;
  assign day_bcd   = bcd2(6'(date_d[DAY_LSB +: DAY_W]));
  assign month_bcd = bcd2(6'(date_d[MONTH_LSB +: MONTH_W]));
  assign year_v    = date_d[YEAR_LSB +: YEAR_W];
  assign year_th   = 4'(year_v / 12'd1000);
  assign year_hu   = 4'((year_v / 12'd100) % 12'd10);
  assign year_te   = 4'((year_v / 12'd10) % 12'd10);
  assign year_on   = 4'(year_v % 12'd10);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      date_q <= '0;
    end else begin
      date_q <= date_d;
    end
  end
`else
  logic unused_date;
  assign unused_date = ^date_in;
`endif

  // Character for the current byte index; the time part is indexed
  // relative to the end of the optional date prefix.
  always_comb begin
    time_idx  = idx_q - 5'(PREFIX_LEN);
    byte_data = ASCII_LF;
    case (time_idx)
      5'd0:    byte_data = ascii_digit(hour_bcd[7:4]);
      5'd1:    byte_data = ascii_digit(hour_bcd[3:0]);
      5'd2:    byte_data = ASCII_COLON;
      5'd3:    byte_data = ascii_digit(min_bcd[7:4]);
      5'd4:    byte_data = ascii_digit(min_bcd[3:0]);
      5'd5:    byte_data = ASCII_COLON;
      5'd6:    byte_data = ascii_digit(sec_bcd[7:4]);
      5'd7:    byte_data = ascii_digit(sec_bcd[3:0]);
      5'd8:    byte_data = ASCII_CR;
      default: byte_data = ASCII_LF;
    endcase
`ifdef DATE_REPORT_EN
    if (idx_q < 5'(PREFIX_LEN)) begin
      case (idx_q)
        5'd0:    byte_data = ascii_digit(day_bcd[7:4]);
        5'd1:    byte_data = ascii_digit(day_bcd[3:0]);
        5'd2:    byte_data = ASCII_DOT;
        5'd3:    byte_data = ascii_digit(month_bcd[7:4]);
        5'd4:    byte_data = ascii_digit(month_bcd[3:0]);
        5'd5:    byte_data = ASCII_DOT;
        5'd6:    byte_data = ascii_digit(year_th);
        5'd7:    byte_data = ascii_digit(year_hu);
        5'd8:    byte_data = ascii_digit(year_te);
        5'd9:    byte_data = ascii_digit(year_on);
        default: byte_data = ASCII_SPACE;
      endcase
    end
`endif
  end

  // Sequencer. launch_q marks the single handover cycle after a byte's
  // done, in which the next byte is started. A trigger landing in the very
  // cycle the last byte finishes is served at once rather than left
  // pending in IDLE.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    launch_d  = 1'b0;
    start     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          state_d = ST_LOAD;
          idx_d   = '0;
        end
      end
      ST_LOAD: begin
        start   = 1'b1;
        state_d = ST_SEND;
        if (trigger) pending_d = 1'b1;
      end
      ST_SEND: begin
        start = launch_q;
        if (trigger) pending_d = 1'b1;
        if (done) begin
          if (idx_q == LAST_IDX) begin
            if (pending_q || trigger) begin
              state_d   = ST_LOAD;
              idx_d     = '0;
              pending_d = 1'b0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            idx_d    = idx_q + 5'd1;
            launch_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      pending_q  <= 1'b0;
      launch_q   <= 1'b0;
      sec_prev_q <= '0;
      time_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pending_q  <= pending_d;
      launch_q   <= launch_d;
      sec_prev_q <= sec_prev_d;
      time_q     <= time_d;
    end
  end

  uart_tx_byte #(
    .DIV(DIV)
  ) u_uart_tx_byte (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .data (byte_data),
    .tx   (tx),
    .done (done)
  );

endmodule

// File: tb/tb_time_report_tx.sv
// tb_time_report_tx - self-checking bench for time_report_tx.
//
// A UART receiver decodes tx into a queue of {stop bit, data byte}. Each
// test pushes the line it expects into a scoreboard queue when it drives
// the request, then pops both queues and compares them.
module tb_time_report_tx;

  localparam int CLK_FREQ = 16;
  localparam int BAUD     = 1;
  localparam int DIV      = CLK_FREQ / BAUD;
`ifdef DATE_REPORT_EN
  localparam int N_BYTES = 21;
`else
  localparam int N_BYTES = 10;
`endif
  // busy stays high for this many cycles counted from the trigger cycle
  localparam int LINE_CYCLES = N_BYTES * (10 * DIV + 1) + 1;

  logic        clk     = 1'b0;
  logic        rst     = 1'b1;
  logic [16:0] time_in = '0;
  logic [20:0] date_in = '0;
  logic        report  = 1'b0;
  logic        auto_en = 1'b0;
  logic        tx;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [8:0] exp_q[$];
  logic [8:0] rx_q[$];
  int         rx_start_q[$];

  time_report_tx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .time_in(time_in),
    .date_in(date_in),
    .report (report),
    .auto_en(auto_en),
    .tx     (tx),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Receiver: a low line while out of reset marks the first cycle of a
  // start bit; every bit is then sampled mid-period. A frame interrupted by
  // reset is discarded.
  initial begin : rx_monitor
    logic [7:0] rx_byte;
    logic       aborted;
    int         start_cyc;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && tx === 1'b0) begin
        start_cyc = cyc;
        aborted   = 1'b0;
        repeat (DIV / 2) @(negedge clk);
        if (rst !== 1'b1 || tx !== 1'b0) aborted = 1'b1;
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          if (rst !== 1'b1) aborted = 1'b1;
          rx_byte[i] = tx;
        end
        repeat (DIV) @(negedge clk);
        if (rst !== 1'b1) aborted = 1'b1;
        if (!aborted) begin
          rx_q.push_back({tx, rx_byte});
          rx_start_q.push_back(start_cyc);
        end
      end
    end
  end

  initial begin : watchdog
    repeat (60000) @(posedge clk);
    $display("[TB] FAIL watchdog: simulation exceeded 60000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [16:0] mk_time(input int h, input int m, input int s);
    return {5'(h), 6'(m), 6'(s)};
  endfunction

  function automatic void push_char(input int c);
    exp_q.push_back({1'b1, 8'(c)});
  endfunction

  function automatic void push_dec2(input int v);
    push_char(48 + (v / 10) % 10);
    push_char(48 + v % 10);
  endfunction

  function automatic void push_line(input logic [16:0] t);
`ifdef DATE_REPORT_EN
    int yr;
    yr = int'(date_in[11:0]);
    push_dec2(int'(date_in[20:16]));
    push_char(46);
    push_dec2(int'(date_in[15:12]));
    push_char(46);
    push_char(48 + yr / 1000);
    push_char(48 + (yr / 100) % 10);
    push_dec2(yr % 100);
    push_char(32);
`endif
    push_dec2(int'(t[16:12]));
    push_char(58);
    push_dec2(int'(t[11:6]));
    push_char(58);
    push_dec2(int'(t[5:0]));
    push_char(13);
    push_char(10);
  endfunction

  // Returns at the negedge of the cycle after the trigger (the LOAD cycle).
  task automatic pulse_report(output int trig_cyc);
    @(negedge clk);
    report   = 1'b1;
    trig_cyc = cyc;
    @(negedge clk);
    report = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int fall_cyc, output bit timed_out);
    timed_out = 1'b1;
    fall_cyc  = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        fall_cyc  = cyc;
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int bad;
    bad = 0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_values: tx=%b busy=%b, expected tx=1 busy=0", tx, busy);
    end
    rst = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL idle_500: %0d cycles with tx!=1 or busy!=0, expected 0", bad);
    end
    checks++;
    if (rx_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL idle_no_bytes: received %0d bytes, expected 0", rx_q.size());
    end
  endtask

  task automatic test_report();
    int trig, fall;
    bit to;
    logic [8:0] got, want;
    rx_start_q.delete();
    time_in = mk_time(13, 5, 42);
    @(negedge clk);
    push_line(time_in);
    pulse_report(trig);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL report_busy_rise: busy=%b in LOAD cycle, expected 1", busy);
    end
    wait_idle(LINE_CYCLES + 100, fall, to);
    checks++;
    if (to) begin
      errors++;
      $display("[TB] FAIL report_timeout: busy still %b, expected 0", busy);
    end
    checks++;
    if (fall - trig != LINE_CYCLES) begin
      errors++;
      $display("[TB] FAIL report_busy_fall: %0d cycles after trigger, expected %0d", fall - trig, LINE_CYCLES);
    end
    checks++;
    if (rx_start_q.size() == 0 || rx_start_q[0] - trig != 2) begin
      errors++;
      $display("[TB] FAIL report_start_bit: %0d cycles after trigger, expected 2",
               (rx_start_q.size() == 0) ? -1 : rx_start_q[0] - trig);
    end
    for (int i = 0; exp_q.size() > 0; i++) begin
      want = exp_q.pop_front();
      checks++;
      if (rx_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL report_byte%0d: nothing received, expected %h", i, want);
      end else begin
        got = rx_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("[TB] FAIL report_byte%0d: got %h, expected %h", i, got, want);
        end
      end
    end
    checks++;
    if (rx_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL report_extra: %0d extra bytes, expected 0", rx_q.size());
      rx_q.delete();
    end
  endtask

  task automatic test_auto();
    int fall;
    bit to;
    logic [8:0] got, want;
    time_in = mk_time(12, 9, 59);
    repeat (5) @(negedge clk);
    auto_en = 1'b1;
    repeat (50) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rx_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL auto_quiet: busy=%b bytes=%0d, expected busy=0 bytes=0", busy, rx_q.size());
    end
    push_line(mk_time(12, 10, 0));
    time_in = mk_time(12, 10, 0);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL auto_busy_rise: busy=%b, expected 1", busy);
    end
    wait_idle(LINE_CYCLES + 100, fall, to);
    checks++;
    if (to) begin
      errors++;
      $display("[TB] FAIL auto_timeout: busy still %b, expected 0", busy);
    end
    for (int i = 0; exp_q.size() > 0; i++) begin
      want = exp_q.pop_front();
      checks++;
      if (rx_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL auto_byte%0d: nothing received, expected %h", i, want);
      end else begin
        got = rx_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("[TB] FAIL auto_byte%0d: got %h, expected %h", i, got, want);
        end
      end
    end
    repeat (400) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rx_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL auto_hold: busy=%b bytes=%0d, expected busy=0 bytes=0", busy, rx_q.size());
      rx_q.delete();
    end
    auto_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    int trig, fall;
    bit to;
    logic [8:0] got, want;
    rx_start_q.delete();
    time_in = mk_time(1, 2, 3);
    @(negedge clk);
    push_line(time_in);
    pulse_report(trig);
    for (int p = 0; p < 2; p++) begin
      repeat (30) @(negedge clk);
      report = 1'b1;
      @(negedge clk);
      report = 1'b0;
    end
    repeat (100) @(negedge clk);
    time_in = mk_time(7, 8, 9);
    push_line(time_in);
    wait_idle(2 * LINE_CYCLES + 100, fall, to);
    checks++;
    if (to) begin
      errors++;
      $display("[TB] FAIL b2b_timeout: busy still %b, expected 0", busy);
    end
    checks++;
    if (fall - trig != 2 * LINE_CYCLES - 1) begin
      errors++;
      $display("[TB] FAIL b2b_busy_fall: %0d cycles after trigger, expected %0d", fall - trig, 2 * LINE_CYCLES - 1);
    end
    checks++;
    if (rx_start_q.size() <= N_BYTES || rx_start_q[N_BYTES] - trig != LINE_CYCLES + 1) begin
      errors++;
      $display("[TB] FAIL b2b_line2_start: %0d cycles after trigger, expected %0d",
               (rx_start_q.size() <= N_BYTES) ? -1 : rx_start_q[N_BYTES] - trig, LINE_CYCLES + 1);
    end
    for (int i = 0; exp_q.size() > 0; i++) begin
      want = exp_q.pop_front();
      checks++;
      if (rx_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL b2b_byte%0d: nothing received, expected %h", i, want);
      end else begin
        got = rx_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("[TB] FAIL b2b_byte%0d: got %h, expected %h", i, got, want);
        end
      end
    end
    repeat (400) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rx_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL b2b_third_line: busy=%b bytes=%0d, expected busy=0 bytes=0", busy, rx_q.size());
      rx_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    int trig, fall;
    bit to;
    logic [8:0] got, want;
    time_in = mk_time(23, 59, 58);
    @(negedge clk);
    push_line(time_in);
    pulse_report(trig);
    to = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (rx_q.size() >= 3) begin
        to = 1'b0;
        break;
      end
    end
    checks++;
    if (to) begin
      errors++;
      $display("[TB] FAIL midreset_wait: %0d bytes received, expected 3", rx_q.size());
    end
    repeat (40) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_outputs: tx=%b busy=%b, expected tx=1 busy=0", tx, busy);
    end
    for (int i = 0; i < 3; i++) begin
      want = exp_q.pop_front();
      checks++;
      if (rx_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL midreset_byte%0d: nothing received, expected %h", i, want);
      end else begin
        got = rx_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("[TB] FAIL midreset_byte%0d: got %h, expected %h", i, got, want);
        end
      end
    end
    exp_q.delete();
    repeat (20) @(negedge clk);
    rst = 1'b1;
    repeat (200) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rx_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL midreset_quiet: busy=%b bytes=%0d, expected busy=0 bytes=0", busy, rx_q.size());
      rx_q.delete();
    end
    rx_start_q.delete();
    time_in = mk_time(10, 20, 30);
    @(negedge clk);
    push_line(time_in);
    pulse_report(trig);
    wait_idle(LINE_CYCLES + 100, fall, to);
    checks++;
    if (to || fall - trig != LINE_CYCLES) begin
      errors++;
      $display("[TB] FAIL fresh_busy_fall: %0d cycles after trigger, expected %0d", fall - trig, LINE_CYCLES);
    end
    for (int i = 0; exp_q.size() > 0; i++) begin
      want = exp_q.pop_front();
      checks++;
      if (rx_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL fresh_byte%0d: nothing received, expected %h", i, want);
      end else begin
        got = rx_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("[TB] FAIL fresh_byte%0d: got %h, expected %h", i, got, want);
        end
      end
    end
  endtask

`ifdef DATE_REPORT_EN
  task automatic test_date();
    int trig, fall, n;
    bit to;
    logic [8:0] got, want;
    date_in = {5'd7, 4'd3, 12'd2021};
    time_in = mk_time(0, 0, 0);
    @(negedge clk);
    push_line(time_in);
    pulse_report(trig);
    wait_idle(LINE_CYCLES + 100, fall, to);
    checks++;
    if (rx_q.size() != 21) begin
      errors++;
      $display("[TB] FAIL date_count: %0d bytes, expected 21", rx_q.size());
    end
    n = 0;
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      checks++;
      if (rx_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL date_byte%0d: nothing received, expected %h", n, want);
      end else begin
        got = rx_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("[TB] FAIL date_byte%0d: got %h, expected %h", n, got, want);
        end
      end
      n++;
    end
  endtask
`endif

  initial begin
    $display("[TB] time_report_tx bench, DIV=%0d, %0d bytes per line", DIV, N_BYTES);
    test_reset();
    test_report();
    test_auto();
    test_back_to_back();
    test_reset_mid();
`ifdef DATE_REPORT_EN
    test_date();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
